// File: rtl/rgb_pkg.sv
// Shared definitions for the three-channel RGB PWM block: channel indices,
// FSM state encoding and default parameter values.
package rgb_pkg;

   // Channel index within the packed {red, green, blue} colour word
   localparam int CH_R   = 2;
   localparam int CH_G   = 1;
   localparam int CH_B   = 0;
   localparam int NUM_CH = 3;

   // Defaults give roughly 1 kHz PWM at 48 MHz with 8-bit duty
   localparam int DEF_WIDTH   = 8;
   localparam int DEF_CLK_DIV = 188;

   // Update FSM: IDLE accepts a colour, WAIT holds it until the next period
   // boundary, FADE keeps stepping once per period until every channel lands
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_FADE = 2'd2
   } state_t;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: holds the live duty, moves it toward the target when the
// top level allows, and produces the registered compare output.
module pwm_channel
   import rgb_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] cnt,
   input  logic [WIDTH-1:0] target,
   input  logic             step_en,
   input  logic             jump_en,
   output logic             at_target,
   output logic             pwm
);

   logic [WIDTH-1:0] cur_duty;
   logic [WIDTH-1:0] step_val;

   // One LSB toward the target, or no change when already there
   assign step_val = (cur_duty < target) ? cur_duty + WIDTH'(1) :
                     (cur_duty > target) ? cur_duty - WIDTH'(1) :
                                           cur_duty;

   // True when this channel will sit on its target once the pending step lands
   assign at_target = (step_val == target);

   // Duty update on period boundaries and registered compare output
   // NOTE: non-blocking (<=) for every register so all of them sample pre-edge values.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cur_duty <= '0;
         pwm      <= 1'b0;
      end else begin
         if (jump_en) begin
            cur_duty <= target;
         end else if (step_en) begin
            cur_duty <= step_val;
         end
         pwm <= (cnt < cur_duty);
      end
   end

endmodule

// File: rtl/rgb_pwm.sv
// Three-channel PWM generator for the Fomu RGB driver. A new colour is taken
// through a valid/ready handshake and applied only at PWM period boundaries,
// either in one jump or as a one-LSB-per-period fade.
module rgb_pwm
   import rgb_pkg::*;
#(
   parameter int CLK_DIV = DEF_CLK_DIV,
   parameter int WIDTH   = DEF_WIDTH,
   parameter bit FADE    = 1'b1
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_valid,
   output logic                      o_ready,
   input  logic [NUM_CH*WIDTH-1:0]   i_rgb,
   output logic                      o_red,
   output logic                      o_green,
   output logic                      o_blue,
   output logic                      o_busy,
   output logic                      o_period
);

   localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [PRE_W-1:0]        pre_cnt;
   logic                    tick;
   logic [WIDTH-1:0]        cnt;
   logic                    pstart;
   logic                    pstart_q;
   logic [NUM_CH*WIDTH-1:0] target;
   logic                    transfer;
   logic                    step_en;
   logic                    jump_en;
   logic [NUM_CH-1:0]       at_target;
   logic [NUM_CH-1:0]       pwm;
   state_t                  state;
   state_t                  state_nxt;

   assign tick     = (pre_cnt == PRE_W'(CLK_DIV - 1));
   assign pstart   = tick && (cnt == '1);
   assign transfer = i_valid && o_ready;

   // Prescaler and PWM counter; the counter wrap marks a period boundary
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pre_cnt <= '0;
         cnt     <= '0;
      end else if (tick) begin
         pre_cnt <= '0;
         cnt     <= cnt + WIDTH'(1);
      end else begin
         pre_cnt <= pre_cnt + PRE_W'(1);
      end
   end

   // Period pulse delayed two cycles to line up with the registered PWM outputs
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pstart_q <= 1'b0;
         o_period <= 1'b0;
      end else begin
         pstart_q <= pstart;
         o_period <= pstart_q;
      end
   end

   // Latch the offered colour on a handshake transfer
   // NOTE: target is reset as well, so a colour accepted before a reset can never resurface.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         target <= '0;
      end else if (transfer) begin
         target <= i_rgb;
      end
   end

   // FSM state register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state: leave IDLE on a transfer, return once every channel has landed
   // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: begin
            if (transfer) state_nxt = ST_WAIT;
         end
         ST_WAIT, ST_FADE: begin
            if (pstart) state_nxt = (!FADE || (&at_target)) ? ST_IDLE : ST_FADE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // FSM outputs: handshake/busy decoded from state, duty updates only on boundaries
   always_comb begin
      o_ready = (state == ST_IDLE);
      o_busy  = (state != ST_IDLE);
      step_en = 1'b0;
      jump_en = 1'b0;
      if ((state != ST_IDLE) && pstart) begin
         if (FADE) step_en = 1'b1;
         else      jump_en = 1'b1;
      end
   end

   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      pwm_channel #(
         .WIDTH (WIDTH)
      ) u_channel (
         .i_clk     (i_clk),
         .i_rst_n   (i_rst_n),
         .cnt       (cnt),
         .target    (target[ch*WIDTH +: WIDTH]),
         .step_en   (step_en),
         .jump_en   (jump_en),
         .at_target (at_target[ch]),
         .pwm       (pwm[ch])
      );
   end

   assign o_red   = pwm[CH_R];
   assign o_green = pwm[CH_G];
   assign o_blue  = pwm[CH_B];

endmodule

// File: tb/tb_rgb_pwm.sv
// Bench for rgb_pwm with CLK_DIV=2, WIDTH=4: one jump-mode and one fade-mode
// instance. Expected per-period high counts are queued when a colour is sent
// and compared when the matching period has been measured.
module tb_rgb_pwm;

   localparam int CLK_DIV = 2;
   localparam int WIDTH   = 4;
   localparam int PERIOD  = (1 << WIDTH) * CLK_DIV;

   typedef struct {
      int   r;
      int   g;
      int   b;
      logic busy;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              j_valid = 1'b0;
   logic              f_valid = 1'b0;
   logic [3*WIDTH-1:0] j_rgb = '0;
   logic [3*WIDTH-1:0] f_rgb = '0;
   logic j_ready, j_red, j_green, j_blue, j_busy, j_period;
   logic f_ready, f_red, f_green, f_blue, f_busy, f_period;
   logic m_ready, m_red, m_green, m_blue, m_busy, m_period;
   bit   sel_fade = 1'b0;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   waited;
   exp_t sb[$];

   always #5 clk = ~clk;

   rgb_pwm #(.CLK_DIV(CLK_DIV), .WIDTH(WIDTH), .FADE(1'b0)) u_jump (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(j_valid), .o_ready(j_ready),
      .i_rgb(j_rgb), .o_red(j_red), .o_green(j_green), .o_blue(j_blue),
      .o_busy(j_busy), .o_period(j_period)
   );

   rgb_pwm #(.CLK_DIV(CLK_DIV), .WIDTH(WIDTH), .FADE(1'b1)) u_fade (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(f_valid), .o_ready(f_ready),
      .i_rgb(f_rgb), .o_red(f_red), .o_green(f_green), .o_blue(f_blue),
      .o_busy(f_busy), .o_period(f_period)
   );

   // Monitor view of whichever instance the current step exercises
   assign m_ready  = sel_fade ? f_ready  : j_ready;
   assign m_red    = sel_fade ? f_red    : j_red;
   assign m_green  = sel_fade ? f_green  : j_green;
   assign m_blue   = sel_fade ? f_blue   : j_blue;
   assign m_busy   = sel_fade ? f_busy   : j_busy;
   assign m_period = sel_fade ? f_period : j_period;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Stay on negedges until the selected instance shows its period pulse
   task automatic wait_period();
      int guard = 0;
      while (m_period !== 1'b1 && guard < 4 * PERIOD) begin
         @(negedge clk);
         guard++;
      end
      if (m_period !== 1'b1) check("period_timeout", m_period, 1);
   endtask

   task automatic expect_period(input int r, input int g, input int b, input logic busy);
      exp_t e;
      e.r = r; e.g = g; e.b = b; e.busy = busy;
      sb.push_back(e);
   endtask

   // Count high cycles per channel over whole periods and score them
   task automatic measure(input int n);
      for (int p = 0; p < n; p++) begin
         int   rc;
         int   gc;
         int   bc;
         logic busy_s;
         exp_t e;
         rc = 0; gc = 0; bc = 0;
         wait_period();
         busy_s = m_busy;
         for (int k = 0; k < PERIOD; k++) begin
            rc += int'(m_red);
            gc += int'(m_green);
            bc += int'(m_blue);
            @(negedge clk);
         end
         if (sb.size() == 0) begin
            check("scoreboard_empty", sb.size(), 1);
         end else begin
            e = sb.pop_front();
            check("period_red_high",   rc, e.r);
            check("period_green_high", gc, e.g);
            check("period_blue_high",  bc, e.b);
            check("period_busy",       busy_s, e.busy);
         end
      end
   endtask

   // Offer one colour just after a period pulse, then confirm it was taken
   task automatic send(input bit to_fade, input logic [3*WIDTH-1:0] v);
      sel_fade = to_fade;
      wait_period();
      if (to_fade) begin f_rgb = v; f_valid = 1'b1; end
      else         begin j_rgb = v; j_valid = 1'b1; end
      @(negedge clk);
      check("send_ready_low", m_ready, 0);
      check("send_busy_high", m_busy, 1);
      f_valid = 1'b0;
      j_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #3;
      check("rst_j_red",    j_red,    0);
      check("rst_j_green",  j_green,  0);
      check("rst_j_blue",   j_blue,   0);
      check("rst_j_period", j_period, 0);
      check("rst_j_ready",  j_ready,  1);
      check("rst_j_busy",   j_busy,   0);
      check("rst_f_red",    f_red,    0);
      check("rst_f_period", f_period, 0);
      check("rst_f_ready",  f_ready,  1);
      check("rst_f_busy",   f_busy,   0);
      #8 rst_n = 1'b1;
      @(negedge clk);

      // Jump mode: {4,0,15} lands in one boundary
      send(1'b0, 12'h40F);
      expect_period(8, 0, 30, 1'b0);
      expect_period(8, 0, 30, 1'b0);
      measure(2);

      // Handshake: valid held high, second value only taken back in IDLE
      sel_fade = 1'b0;
      wait_period();
      j_rgb   = 12'h111;
      j_valid = 1'b1;
      @(negedge clk);
      check("hs_first_accept", j_ready, 0);
      j_rgb  = 12'h999;
      waited = 0;
      while (j_ready === 1'b0 && waited < 4 * PERIOD) begin
         @(negedge clk);
         waited++;
      end
      check("hs_ready_low_cycles", waited, 30);
      @(negedge clk);
      check("hs_second_accept", j_ready, 0);
      check("hs_second_busy",   j_busy,  1);
      j_valid = 1'b0;
      expect_period(2, 2, 2, 1'b1);
      expect_period(18, 18, 18, 1'b0);
      measure(2);

      // Fade up: red 1, 2, 3 on successive boundaries
      send(1'b1, 12'h300);
      expect_period(2, 0, 0, 1'b1);
      expect_period(4, 0, 0, 1'b1);
      expect_period(6, 0, 0, 1'b0);
      measure(3);

      // Bring red to 5 for the mixed fade
      send(1'b1, 12'h500);
      expect_period(8, 0, 0, 1'b1);
      expect_period(10, 0, 0, 1'b0);
      measure(2);

      // Mixed fade: red down 4,3,2 while green rises 1,2 and holds
      send(1'b1, 12'h220);
      expect_period(8, 2, 0, 1'b1);
      expect_period(6, 4, 0, 1'b1);
      expect_period(4, 4, 0, 1'b0);
      measure(3);

      // No-op update: busy only until the next boundary, duties unchanged
      send(1'b1, 12'h220);
      expect_period(4, 4, 0, 1'b0);
      expect_period(4, 4, 0, 1'b0);
      measure(2);

      // Reset mid-fade toward white
      send(1'b1, 12'hFFF);
      expect_period(6, 6, 2, 1'b1);
      measure(1);
      check("pre_rst_red",  f_red,  1);
      check("pre_rst_busy", f_busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_red",    f_red,    0);
      check("mid_rst_green",  f_green,  0);
      check("mid_rst_blue",   f_blue,   0);
      check("mid_rst_period", f_period, 0);
      check("mid_rst_ready",  f_ready,  1);
      check("mid_rst_busy",   f_busy,   0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_ready", f_ready, 1);
      check("post_rst_busy",  f_busy,  0);
      expect_period(0, 0, 0, 1'b0);
      measure(1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
